// File: rtl/toplevel_soc_pio_pkg.sv
// Shared constants for the SoC input PIO: register offsets and
// edge-capture mode encodings.
package toplevel_soc_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA     = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE     = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_input_debounce.sv
// One input line: 2-flop synchroniser followed by a stability counter
// that accepts a new level only after N consecutive differing cycles.
module pio_input_debounce #(
    parameter int N = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable
);

    logic meta;
    logic sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
        end
    end

    generate
        if (N == 0) begin : g_bypass
            assign stable = sync;
        end else begin : g_deb
            localparam int CW = $clog2(N + 1);
            logic [CW-1:0] cnt;
            logic          stable_q;

            // Count only while the synchronised level disagrees.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt      <= '0;
                    stable_q <= 1'b0;
                end else if (sync == stable_q) begin
                    cnt <= '0;
                end else if (cnt == CW'(N - 1)) begin
                    stable_q <= sync;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign stable = stable_q;
        end
    endgenerate

endmodule

// File: rtl/toplevel_soc_keys_pio.sv
// Avalon-MM input PIO: debounced key/pad lines with per-bit edge
// capture and a maskable interrupt.
import toplevel_soc_pio_pkg::*;

module toplevel_soc_keys_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      rd_next;
    logic             wr;

    wire unused_wdata = &{1'b0, writedata};

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_line
            pio_input_debounce #(
                .N(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk    (clk),
                .reset_n(reset_n),
                .din    (in_port[i]),
                .stable (stable[i])
            );
        end
    endgenerate

    assign wr    = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];
    assign rise  = stable & ~stable_d;
    assign fall  = ~stable & stable_d;

    assign edge_hit = (EDGE_TYPE == EDGE_FALL) ? fall :
                      (EDGE_TYPE == EDGE_ANY)  ? (rise | fall) :
                                                 rise;

    assign w1c = (wr && address == PIO_ADDR_EDGE) ? wdata : '0;

    always_comb begin
        rd_next = '0;
        unique case (address)
            PIO_ADDR_DATA:     rd_next[WIDTH-1:0] = stable;
            PIO_ADDR_IRQ_MASK: rd_next[WIDTH-1:0] = irq_mask;
            PIO_ADDR_EDGE:     rd_next[WIDTH-1:0] = edge_capture;
            default:           rd_next = '0;
        endcase
    end

    // A new edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d     <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
        end else begin
            stable_d     <= stable;
            edge_capture <= (edge_capture & ~w1c) | edge_hit;
            readdata     <= rd_next;
            if (wr && address == PIO_ADDR_IRQ_MASK)
                irq_mask <= wdata;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_toplevel_soc_keys_pio.sv
// Bench for the input PIO: directed scenarios plus random traffic,
// all compared against a behavioural model of the register block.
module tb_toplevel_soc_keys_pio;

    localparam int W = 4;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   address = '0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = '0;
    logic [W-1:0] in_port = '0;
    logic [31:0]  readdata;
    logic         irq;

    int n_tests = 0;
    int n_fail  = 0;

    toplevel_soc_keys_pio #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(N),
        .EDGE_TYPE      (0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: sync = in_port two edges late; a level is accepted once
    // the last N synchronised samples all differ from the held level.
    logic [W-1:0] m_d1, m_d2, m_stable, m_prev, m_ec, m_mask;
    logic [31:0]  m_rd;
    logic [W-1:0] hist[$];

    function automatic void m_reset();
        m_d1 = '0; m_d2 = '0; m_stable = '0; m_prev = '0;
        m_ec = '0; m_mask = '0; m_rd = '0;
        hist.delete();
    endfunction

    function automatic void m_edge();
        logic         wr;
        logic [W-1:0] w1c, flip;
        wr = chipselect && !write_n;
        case (address)
            2'd0:    m_rd = 32'(m_stable);
            2'd2:    m_rd = 32'(m_mask);
            2'd3:    m_rd = 32'(m_ec);
            default: m_rd = 32'd0;
        endcase
        w1c = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
        m_ec = (m_ec & ~w1c) | (m_stable & ~m_prev);
        if (wr && address == 2'd2) m_mask = writedata[W-1:0];
        hist.push_back(m_d2);
        if (hist.size() > N) void'(hist.pop_front());
        m_prev = m_stable;
        flip = '0;
        if (hist.size() == N) begin
            for (int b = 0; b < W; b++) begin
                flip[b] = 1'b1;
                foreach (hist[k]) if (hist[k][b] == m_stable[b]) flip[b] = 1'b0;
            end
        end
        m_stable = m_stable ^ flip;
        m_d2 = m_d1;
        m_d1 = in_port;
    endfunction

    task automatic step();
        @(posedge clk);
        if (reset_n) m_edge();
        #1;
        check("readdata", readdata, m_rd);
        check("irq", 32'(irq), 32'(|(m_ec & m_mask)));
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a,
                          input logic [31:0] exp);
        address = a;
        step();
        check(tag, readdata, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        m_reset();
        #1;
        check("rst_rd", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        repeat (3) step();
        reset_n = 1'b1;
        rd_chk("t1_off0", 2'd0, 32'h0);
        rd_chk("t1_off1", 2'd1, 32'h0);
        rd_chk("t1_off2", 2'd2, 32'h0);
        rd_chk("t1_off3", 2'd3, 32'h0);

        address = 2'd0;
        in_port = 4'b0001;
        repeat (6) step();
        check("t2_data_early", readdata, 32'h0);
        step();
        check("t2_data", readdata, 32'h1);
        rd_chk("t2_edge", 2'd3, 32'h1);
        check("t2_irq_masked", 32'(irq), 32'h0);
        bus_wr(2'd2, 32'h1);
        check("t2_irq", 32'(irq), 32'h1);

        address = 2'd0;
        in_port = 4'b0011;
        repeat (3) step();
        in_port = 4'b0001;
        repeat (10) step();
        rd_chk("t3_data", 2'd0, 32'h1);
        rd_chk("t3_edge", 2'd3, 32'h1);
        check("t3_irq", 32'(irq), 32'h1);

        bus_wr(2'd3, 32'h1);
        check("t4_irq_drop", 32'(irq), 32'h0);
        rd_chk("t4_edge_clr", 2'd3, 32'h0);
        in_port = 4'b0000;
        repeat (10) step();
        rd_chk("t5_fall_data", 2'd0, 32'h0);
        rd_chk("t5_fall_edge", 2'd3, 32'h0);
        in_port = 4'b0001;
        repeat (6) step();
        bus_wr(2'd3, 32'h1);
        check("t4_set_wins_irq", 32'(irq), 32'h1);
        rd_chk("t4_set_wins", 2'd3, 32'h1);
        bus_wr(2'd3, 32'hF);

        address = 2'd0;
        in_port = 4'b0100;
        repeat (4) step();
        #2 reset_n = 1'b0;
        #1;
        m_reset();
        check("t5_rst_rd", readdata, 32'h0);
        check("t5_rst_irq", 32'(irq), 32'h0);
        step();
        reset_n = 1'b1;
        repeat (6) step();
        check("t5_rst_early", readdata, 32'h0);
        step();
        check("t5_rst_data", readdata, 32'h4);

        bus_wr(2'd0, 32'hF);
        bus_wr(2'd1, 32'hF);
        rd_chk("t6_off1", 2'd1, 32'h0);
        rd_chk("t6_off0", 2'd0, 32'h4);
        address = 2'd2; writedata = 32'hF; chipselect = 1'b0; write_n = 1'b0;
        step();
        write_n = 1'b1;
        rd_chk("t6_mask", 2'd2, 32'h0);

        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0)
                in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
            address    = 2'($urandom);
            writedata  = $urandom;
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
